muladd_stream: RTL and testbench

MULADD_STREAM -- requirements
Module: muladd_stream

---
 rtl/muladd_stream.sv | 116 +++++++++++
 tb/tb_muladd_stream.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/muladd_stream.sv
// Streaming multiply-add: each three-sample run window (a,b,c) yields a*b+c.
// Ports: clk, rst (sync high), validi/data_in in; valido/data_out/ovf out.
module muladd_stream #(
  parameter int WIDTH   = 8,
  parameter int OUT_W   = 16,
  parameter bit SAT     = 1'b0,
  parameter bit SLIDING = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validi,
  input  logic [WIDTH-1:0] data_in,
  output logic             valido,
  output logic [OUT_W-1:0] data_out,
  output logic             ovf
);

  localparam int FW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2,
    FULL = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;

  logic             trig;
  logic [2*WIDTH-1:0] prod;
  logic [FW-1:0]    full;
  logic             ovf_c;
  logic [OUT_W-1:0] res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    trig      = 1'b0;
    if (!validi) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: state_nxt = ONE;
        ONE:  state_nxt = TWO;
        TWO: begin
          state_nxt = FULL;
          trig      = 1'b1;
        end
        FULL: begin
          if (SLIDING) begin
            state_nxt = FULL;
            trig      = 1'b1;
          end else begin
            state_nxt = ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The incoming sample is the newest operand on a trigger edge, so the
  // result uses the two held samples (b oldest, c middle) plus data_in.
  always_comb begin
    prod  = b * c;
    full  = {1'b0, prod} + {{(WIDTH + 1){1'b0}}, data_in};
    ovf_c = (full >> OUT_W) != '0;
    res   = full[OUT_W-1:0];
    if (SAT && ovf_c) begin
      res = {OUT_W{1'b1}};
    end
  end

  // Window shifts on every valid sample; a broken run clears it.
  always_ff @(posedge clk) begin
    if (rst || !validi) begin
      a <= '0;
      b <= '0;
      c <= '0;
    end else begin
      a <= b;
      b <= c;
      c <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valido   <= 1'b0;
      ovf      <= 1'b0;
      data_out <= '0;
    end else begin
      valido <= trig;
      ovf    <= trig & ovf_c;
      if (trig) begin
        data_out <= res;
      end
    end
  end

  logic unused;
  assign unused = ^a;

endmodule

// File: tb/tb_muladd_stream.sv
// Self-checking bench for muladd_stream: four parameter variants driven
// together and compared against a queue-based reference model.
module tb_muladd_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       validi;
  logic [7:0] data_in;

  logic        v0, v1, v2, v3;
  logic        o0, o1, o2, o3;
  logic [15:0] d0;
  logic [7:0]  d1;
  logic [7:0]  d2;
  logic [15:0] d3;

  int checks = 0;
  int errors = 0;

  int qs[$];
  int qn[$];
  int ev[4];
  int ed[4];
  int eo[4];

  always #5 clk = ~clk;

  muladd_stream #(.WIDTH(8), .OUT_W(16), .SAT(1'b0), .SLIDING(1'b1)) u0 (
    .clk(clk), .rst(rst), .validi(validi), .data_in(data_in),
    .valido(v0), .data_out(d0), .ovf(o0));
  muladd_stream #(.WIDTH(8), .OUT_W(8), .SAT(1'b0), .SLIDING(1'b1)) u1 (
    .clk(clk), .rst(rst), .validi(validi), .data_in(data_in),
    .valido(v1), .data_out(d1), .ovf(o1));
  muladd_stream #(.WIDTH(8), .OUT_W(8), .SAT(1'b1), .SLIDING(1'b1)) u2 (
    .clk(clk), .rst(rst), .validi(validi), .data_in(data_in),
    .valido(v2), .data_out(d2), .ovf(o2));
  muladd_stream #(.WIDTH(8), .OUT_W(16), .SAT(1'b0), .SLIDING(1'b0)) u3 (
    .clk(clk), .rst(rst), .validi(validi), .data_in(data_in),
    .valido(v3), .data_out(d3), .ovf(o3));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void result(input int i, input int x, input int y,
                                 input int z);
    int full;
    int ow;
    int mx;
    bit sat;
    full = x * y + z;
    ow   = (i == 1 || i == 2) ? 8 : 16;
    sat  = (i == 2);
    mx   = (1 << ow) - 1;
    ev[i] = 1;
    eo[i] = (full > mx) ? 1 : 0;
    ed[i] = sat ? ((full > mx) ? mx : full) : (full & mx);
  endfunction

  function automatic void model(input bit r, input bit v, input int d);
    for (int i = 0; i < 4; i++) begin
      ev[i] = 0;
      eo[i] = 0;
    end
    if (r) begin
      qs.delete();
      qn.delete();
      for (int i = 0; i < 4; i++) ed[i] = 0;
    end else if (!v) begin
      qs.delete();
      qn.delete();
    end else begin
      qs.push_back(d);
      qn.push_back(d);
      if (qs.size() == 3) begin
        for (int i = 0; i < 3; i++) result(i, qs[0], qs[1], qs[2]);
        void'(qs.pop_front());
      end
      if (qn.size() == 3) begin
        result(3, qn[0], qn[1], qn[2]);
        qn.delete();
      end
    end
  endfunction

  task automatic check_all();
    chk("u0.valido", int'(v0), ev[0]);
    chk("u0.data", int'(d0), ed[0]);
    chk("u0.ovf", int'(o0), eo[0]);
    chk("u1.valido", int'(v1), ev[1]);
    chk("u1.data", int'(d1), ed[1]);
    chk("u1.ovf", int'(o1), eo[1]);
    chk("u2.valido", int'(v2), ev[2]);
    chk("u2.data", int'(d2), ed[2]);
    chk("u2.ovf", int'(o2), eo[2]);
    chk("u3.valido", int'(v3), ev[3]);
    chk("u3.data", int'(d3), ed[3]);
    chk("u3.ovf", int'(o3), eo[3]);
  endtask

  task automatic step(input bit r, input bit v, input int d);
    @(negedge clk);
    rst     = r;
    validi  = v;
    data_in = 8'(d);
    @(posedge clk);
    model(r, v, d);
    #1;
    check_all();
  endtask

  int nv;

  initial begin
    rst     = 1'b1;
    validi  = 1'b0;
    data_in = '0;
    step(1, 0, 0);
    step(1, 1, 9);

    // 3,4,5 -> 17
    step(0, 1, 3);
    step(0, 1, 4);
    chk("ex1.pre_valido", int'(v0), 0);
    step(0, 1, 5);
    chk("ex1.valido", int'(v0), 1);
    chk("ex1.data", int'(d0), 17);
    chk("ex1.ovf", int'(o0), 0);
    step(0, 0, 0);
    chk("ex1.hold", int'(d0), 17);

    // 20,20,5 with 8-bit output
    step(0, 1, 20);
    step(0, 1, 20);
    step(0, 1, 5);
    chk("wrap.data", int'(d1), 149);
    chk("wrap.ovf", int'(o1), 1);
    chk("sat.data", int'(d2), 255);
    chk("sat.ovf", int'(o2), 1);
    step(0, 0, 0);
    chk("sat.ovf_low", int'(o2), 0);

    // broken runs never produce a result
    step(1, 0, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 0, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 0, 0);
    chk("broken.valido", int'(v0), 0);
    chk("broken.data", int'(d0), 0);

    // continuous 1..6
    step(0, 1, 1);
    step(0, 1, 2);
    step(0, 1, 3);
    chk("slide.r1", int'(d0), 5);
    chk("block.r1", int'(d3), 5);
    step(0, 1, 4);
    chk("slide.r2", int'(d0), 10);
    chk("slide.v2", int'(v0), 1);
    chk("block.v_gap", int'(v3), 0);
    step(0, 1, 5);
    step(0, 1, 6);
    chk("block.r2", int'(d3), 26);
    chk("block.v2", int'(v3), 1);
    step(0, 0, 0);

    // reset in the middle of a run
    step(0, 1, 7);
    step(0, 1, 8);
    step(1, 1, 9);
    nv = 0;
    step(0, 1, 2);
    nv += int'(v0);
    step(0, 1, 3);
    nv += int'(v0);
    step(0, 1, 4);
    nv += int'(v0);
    chk("rstrun.data", int'(d0), 10);
    step(0, 0, 0);
    nv += int'(v0);
    chk("rstrun.count", nv, 1);

    // reset in the valido cycle
    step(0, 1, 2);
    step(0, 1, 3);
    step(0, 1, 4);
    chk("rstv.valido", int'(v0), 1);
    step(1, 0, 0);
    chk("rstv.data", int'(d0), 0);
    chk("rstv.v", int'(v0), 0);

    // extremes
    step(0, 1, 255);
    step(0, 1, 255);
    step(0, 1, 255);
    chk("max.data", int'(d0), 65280);
    step(0, 1, 0);
    step(0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit r;
      bit v;
      int d;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 5))
        0: d = 0;
        1: d = 255;
        default: d = int'($urandom_range(0, 255));
      endcase
      step(r, v, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
